// File: rtl/cpu_mem_responder.sv
// Purpose: single-array 32-bit word memory serving an instruction-fetch port and a data load/store port.
// Latency: reads return one cycle after the request (registered outputs); stores take effect at the request edge.
// Backpressure: none; both ports accept a request every cycle and never stall.
module cpu_mem_responder #(
   parameter int WORDS = 16384,
   parameter int AW    = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_read,
   input  logic [31:0] instr_addr,
   output logic [31:0] instr_out,
   input  logic        data_read,
   input  logic [3:0]  data_write,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        addr_err
);

   // Shared storage; deliberately not reset so preloaded contents survive rst.
   logic [31:0] mem [0:WORDS-1];

   logic [AW-1:0] instr_idx;
   logic [AW-1:0] data_idx;
   logic          instr_ok;
   logic          data_ok;
   logic          store_req;
   logic          err_now;
   logic          unused_low_bits;

   // Byte offsets within a word carry no meaning for whole-word ports.
   assign unused_low_bits = ^{instr_addr[1:0], data_addr[1:0]};

   assign instr_idx = instr_addr[AW+1:2];
   assign data_idx  = data_addr[AW+1:2];

   // Any set bit above the array span is out of range; no aliasing onto low memory.
   assign instr_ok  = (instr_addr[31:AW+2] == '0);
   assign data_ok   = (data_addr[31:AW+2] == '0);

   assign store_req = (data_write != 4'b0000);

   assign err_now = (instr_read && !instr_ok) ||
                    (data_read  && !data_ok)  ||
                    (store_req  && !data_ok);

   // Byte-lane store; reads in the same cycle see the old word because all updates are non-blocking.
   always_ff @(posedge clk) begin
      if (!rst && store_req && data_ok) begin
         for (int n = 0; n < 4; n++) begin
            if (data_write[n]) begin
               mem[data_idx][8*n +: 8] <= data_in[8*n +: 8];
            end
         end
      end
   end

   // Instruction fetch register: loads on request (zero when out of range), otherwise holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_out <= 32'h0;
      end else if (instr_read) begin
         instr_out <= instr_ok ? mem[instr_idx] : 32'h0;
      end
   end

   // Data load register: full word returned, extension is the initiator's job.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= 32'h0;
      end else if (data_read) begin
         data_out <= data_ok ? mem[data_idx] : 32'h0;
      end
   end

   // Sticky out-of-range flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_err <= 1'b0;
      end else if (err_now) begin
         addr_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Purpose: randomized and directed self-checking bench for cpu_mem_responder against a word-array reference model.
// Latency: model expectations are formed one cycle after inputs are applied and compared #1 after the edge.
// Backpressure: not applicable; the DUT never stalls.
module tb_cpu_mem_responder;

   logic        clk;
   logic        rst;
   logic        instr_read;
   logic [31:0] instr_addr;
   logic [31:0] instr_out;
   logic        data_read;
   logic [3:0]  data_write;
   logic [31:0] data_addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        addr_err;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] m_mem [0:16383];
   logic [31:0] e_instr;
   logic [31:0] e_data;
   logic        e_err;

   cpu_mem_responder #(.WORDS(16384), .AW(14)) dut (
      .clk        (clk),
      .rst        (rst),
      .instr_read (instr_read),
      .instr_addr (instr_addr),
      .instr_out  (instr_out),
      .data_read  (data_read),
      .data_write (data_write),
      .data_addr  (data_addr),
      .data_in    (data_in),
      .data_out   (data_out),
      .addr_err   (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   // 16384 words * 4 bytes = 64 KiB of address space; anything at or above is out of range.
   function automatic bit in_range(input logic [31:0] a);
      return a < 32'h0001_0000;
   endfunction

   // One clock: predict results from the pre-edge memory image, then apply the store.
   task automatic cycle();
      @(posedge clk);
      #1;
      if (rst) begin
         e_instr = 32'h0;
         e_data  = 32'h0;
         e_err   = 1'b0;
      end else begin
         if (instr_read) begin
            if (in_range(instr_addr)) e_instr = m_mem[instr_addr / 4];
            else begin e_instr = 32'h0; e_err = 1'b1; end
         end
         if (data_read) begin
            if (in_range(data_addr)) e_data = m_mem[data_addr / 4];
            else begin e_data = 32'h0; e_err = 1'b1; end
         end
         if (data_write != 4'b0000) begin
            if (in_range(data_addr)) begin
               for (int n = 0; n < 4; n++)
                  if (data_write[n]) m_mem[data_addr / 4][8*n +: 8] = data_in[8*n +: 8];
            end else begin
               e_err = 1'b1;
            end
         end
      end
      check("instr_out", instr_out, e_instr);
      check("data_out", data_out, e_data);
      check("addr_err", {31'b0, addr_err}, {31'b0, e_err});
   endtask

   task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] di);
      rst        = r;
      instr_read = ir;
      instr_addr = ia;
      data_read  = dr;
      data_write = dw;
      data_addr  = da;
      data_in    = di;
      cycle();
   endtask

   task automatic store(input logic [31:0] a, input logic [3:0] dw, input logic [31:0] d);
      step(1'b0, 1'b0, 32'h0, 1'b0, dw, a, d);
   endtask

   task automatic load(input logic [31:0] a);
      step(1'b0, 1'b0, 32'h0, 1'b1, 4'b0000, a, 32'h0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
   endtask

   // Random address: mostly words 0..63 with arbitrary low bits, occasionally out of range.
   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      if ($urandom_range(0, 11) == 0) begin
         a = $urandom | 32'h0001_0000;
      end else begin
         a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
      end
      return a;
   endfunction

   initial begin
      e_instr = 32'h0;
      e_data  = 32'h0;
      e_err   = 1'b0;

      // Reset state
      step(1'b1, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
      check("reset_instr_out", instr_out, 32'h0);
      check("reset_addr_err", {31'b0, addr_err}, 32'h0);

      // Give the low 64 words known contents through the store port.
      for (int w = 0; w < 64; w++) store(w * 4, 4'b1111, $urandom);

      // Instruction fetch and hold
      store(32'h8, 4'b1111, 32'h00500093);
      step(1'b0, 1'b1, 32'h8, 1'b0, 4'b0000, 32'h0, 32'h0);
      check("fetch_0x8", instr_out, 32'h00500093);
      step(1'b0, 1'b0, 32'h10, 1'b0, 4'b0000, 32'h0, 32'h0);
      check("fetch_hold", instr_out, 32'h00500093);

      // Partial-lane overwrite
      store(32'h40, 4'b1111, 32'hDEADBEEF);
      store(32'h40, 4'b0100, 32'h00AA0000);
      load(32'h40);
      check("lane2_merge", data_out, 32'hDEAABEEF);

      // Same-word collision: fetch sees the pre-write word
      store(32'h10, 4'b1111, 32'hCAFEF00D);
      step(1'b0, 1'b1, 32'h10, 1'b0, 4'b1111, 32'h10, 32'h12345678);
      check("collide_old", instr_out, 32'hCAFEF00D);
      step(1'b0, 1'b1, 32'h10, 1'b0, 4'b0000, 32'h0, 32'h0);
      check("collide_new", instr_out, 32'h12345678);

      // Load and store together on the same word
      step(1'b0, 1'b0, 32'h0, 1'b1, 4'b1111, 32'h10, 32'h55AA55AA);
      check("ld_st_old", data_out, 32'h12345678);
      load(32'h10);
      check("ld_st_new", data_out, 32'h55AA55AA);

      // Out-of-range load and store
      store(32'h0, 4'b1111, 32'h0BADCAFE);
      load(32'h0001_0000);
      check("oor_load_data", data_out, 32'h0);
      check("oor_load_err", {31'b0, addr_err}, 32'h1);
      store(32'h0001_0000, 4'b1111, 32'hFFFFFFFF);
      load(32'h0);
      check("oor_no_wrap", data_out, 32'h0BADCAFE);
      idle();
      idle();
      check("err_sticky", {31'b0, addr_err}, 32'h1);

      // Reset concurrent with a store
      store(32'h20, 4'b1111, 32'h11111111);
      step(1'b0, 1'b1, 32'h20, 1'b1, 4'b0000, 32'h20, 32'h0);
      step(1'b1, 1'b1, 32'h20, 1'b1, 4'b1111, 32'h20, 32'h22222222);
      check("rst_data_out", data_out, 32'h0);
      check("rst_instr_out", instr_out, 32'h0);
      check("rst_err", {31'b0, addr_err}, 32'h0);
      load(32'h20);
      check("rst_store_ignored", data_out, 32'h11111111);

      // Lane sweep at 0x30
      store(32'h30, 4'b1111, 32'h0);
      store(32'h30, 4'b0001, 32'hFFFFFFA1);
      load(32'h30);
      check("lane0", data_out, 32'h000000A1);
      store(32'h30, 4'b0010, 32'hFFFFB2FF);
      load(32'h30);
      check("lane1", data_out, 32'h0000B2A1);
      store(32'h30, 4'b1000, 32'hC3FFFFFF);
      load(32'h30);
      check("lane3", data_out, 32'hC300B2A1);
      store(32'h30, 4'b0110, 32'hFFD4E5FF);
      load(32'h33);
      check("lanes12", data_out, 32'hC3D4E5A1);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic        r;
         logic [3:0]  dw;
         r  = ($urandom_range(0, 199) == 0);
         dw = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
         step(r, 1'($urandom), rand_addr(), 1'($urandom), dw, rand_addr(), $urandom);
      end

      // Final reset clears the flag
      step(1'b1, 1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
      check("final_rst_err", {31'b0, addr_err}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter WORDS, default 16384: memory depth in 32-bit words; power of two, 16 to 65536.
REQ-002 Parameter AW, default 14: word-index width, equal to log2(WORDS).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 instr_read  input  1  instruction-fetch request strobe.
REQ-006 instr_addr  input  32  instruction byte address.
REQ-007 instr_out  output  32  registered instruction word.
REQ-008 data_read  input  1  data-load request strobe.
REQ-009 data_write  input  4  byte-lane write strobes; bit n covers data bits [8n+7:8n].
REQ-010 data_addr  input  32  data byte address, shared by loads and stores.
REQ-011 data_in  input  32  store data, already lane-aligned by the initiator.
REQ-012 data_out  output  32  registered load word.
REQ-013 addr_err  output  1  sticky flag: at least one out-of-range access since reset.

Function
REQ-014 Storage SHALL be a single array of WORDS 32-bit words, shared by both ports.
REQ-015 Word index SHALL be addr[AW+1:2]; addr[1:0] SHALL be ignored on both ports.
REQ-016 An address SHALL be in range iff addr[31:AW+2] == 0.
REQ-017 Instruction port: a cycle with instr_read=1 and an in-range instr_addr SHALL load instr_out with the addressed word at that rising edge, so the word is visible one cycle after the request.
REQ-018 Instruction port: instr_out SHALL hold its last value in any cycle with instr_read=0.
REQ-019 Data load: a cycle with data_read=1 and an in-range data_addr SHALL load data_out with the addressed word at that edge.
REQ-020 Data load: data_out SHALL hold its last value until the next data_read; the full word SHALL be returned and sign or zero extension is left to the initiator.
REQ-021 Store: in a cycle with data_write!=0 and an in-range data_addr, each byte lane n with data_write[n]=1 SHALL take data_in[8n+7:8n]; lanes with strobe 0 SHALL keep their value.
REQ-022 Store: a write SHALL complete in the cycle it is presented; there is no busy or stall signal.
REQ-023 Same-word collision: a data write and a read (instruction or data) to the same word in one cycle SHALL give the read the pre-write word; the new value SHALL be visible from the next access onward.
REQ-024 data_read and data_write!=0 together SHALL both be performed, with the ordering of REQ-023.
REQ-025 Out-of-range read SHALL load 32'h0 into the requesting output register and SHALL set addr_err.
REQ-026 Out-of-range write SHALL leave memory unchanged and SHALL set addr_err.
REQ-027 addr_err SHALL stay at 1 until rst.
REQ-028 Address compare SHALL be unsigned 32-bit; there is no wrap-around onto low memory.
REQ-029 Both ports SHALL operate fully in parallel every cycle, with no arbitration and no added latency.

Reset
REQ-030 With rst=1 at a rising edge, instr_out and data_out SHALL become 32'h0 and addr_err SHALL become 0.
REQ-031 With rst=1, any read or write presented in that cycle SHALL be ignored.
REQ-032 Memory contents SHALL NOT be changed by reset; a bench may preload the array through hierarchical access before releasing rst.
REQ-033 After rst deasserts, the first request SHALL be served in the first cycle, with no warm-up.

Verification
REQ-034 Reset, then instr_read=1, instr_addr=0x8 with word[2]=0x00500093 -> instr_out=0x00500093 one cycle later; it holds after instr_read drops to 0.
REQ-035 Store 0xDEADBEEF to 0x40 with data_write=4'b1111, then data_write=4'b0100 with data_in=0x00AA0000 at 0x40, then data_read at 0x40 -> data_out=0xDEAABEEF.
REQ-036 Same cycle: data_write=4'b1111, data_in=0x12345678, data_addr=0x10, instr_read=1, instr_addr=0x10, old word 0xCAFEF00D -> instr_out=0xCAFEF00D; the next fetch of 0x10 returns 0x12345678.
REQ-037 data_read at 0x0001_0000 (WORDS=16384) -> data_out=0 and addr_err=1. A write to the same address leaves word[0] unchanged, and addr_err stays 1 until rst.
REQ-038 Reset mid-stream: assert rst in the same cycle as data_write=4'b1111 to 0x20 -> word[8] is unchanged, data_out=0, instr_out=0, addr_err=0.
REQ-039 Lane sweep: store a single byte through each strobe 4'b0001, 4'b0010, 4'b1000 and a halfword through 4'b0110 at 0x30 -> readback shows only the strobed lanes modified.
